// File: rtl/pulse_window_ctrl.sv
// Window sequencer for an external 3-bit pulse counter: clears it, gates its enable from pulse_in
// rising edges, extends overflows into upper bits and presents a per-window total on a valid/ready port.
// Optional build macro PWC_AUTO_RESTART_EN: result handshake with start high re-enters CLEAR directly.
module pulse_window_ctrl #(
    parameter int  WIN_CYCLES = 1000,
    parameter int  TMR_W      = 16,
    parameter int  EXT_W      = 8,
    localparam int RES_W      = EXT_W + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pulse_in,
    input  logic [2:0]       cnt_count,
    input  logic             cnt_overflow,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             sat,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_CAPTURE,
        S_HOLD
    } state_t;

    localparam logic [TMR_W-1:0] TIMER_LOAD = TMR_W'(WIN_CYCLES - 1);

    state_t             state_q, state_d;
    logic               pulse_prev_q, pulse_prev_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [EXT_W-1:0]   ext_q, ext_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               sat_q, sat_d;
    logic               pulse_edge;

    assign pulse_edge   = pulse_in & ~pulse_prev_q;
    assign cnt_en       = (state_q == S_COUNT) & pulse_edge;
    // Held high through reset so the counter is cleared by any clock edge seen during reset.
    assign cnt_clr      = ~rst_n | (state_q == S_CLEAR);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign sat          = sat_q;
    assign busy         = (state_q != S_IDLE);

    always_comb begin
        state_d        = state_q;
        pulse_prev_d   = pulse_in;
        timer_d        = timer_q;
        ext_d          = ext_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        sat_d          = sat_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ext_d   = '0;
                sat_d   = 1'b0;
                timer_d = TIMER_LOAD;
                state_d = stop ? S_CAPTURE : S_COUNT;
            end
            S_COUNT: begin
                // Counter wraps 7->0 on this same edge; the carry lands in ext, which saturates.
                if (cnt_en && cnt_overflow) begin
                    if (ext_q != '1) begin
                        ext_d = ext_q + 1'b1;
                    end else begin
                        sat_d = 1'b1;
                    end
                end
                if ((timer_q == '0) || stop) begin
                    state_d = S_CAPTURE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                result_d       = sat_q ? '1 : {ext_q, cnt_count};
                result_valid_d = 1'b1;
                state_d        = S_HOLD;
            end
            S_HOLD: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
`ifdef PWC_AUTO_RESTART_EN
                    state_d        = start ? S_CLEAR : S_IDLE;
`else
                    state_d        = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pulse_prev_q   <= 1'b0;
            timer_q        <= '0;
            ext_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            sat_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pulse_prev_q   <= pulse_prev_d;
            timer_q        <= timer_d;
            ext_q          <= ext_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            sat_q          <= sat_d;
        end
    end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Bench for pulse_window_ctrl: vector table, random windows against an edge-counting model,
// plus hand sequences for reset abort and ext saturation (second instance, EXT_W=1).
module tb_pulse_window_ctrl;

    localparam int WIN    = 20;
    localparam int RES_W  = 11;
    localparam int WIN_S  = 40;
    localparam int RES_WS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic             start = 0, stop = 0, pulse_in = 0, result_ready = 0;
    logic [2:0]       cnt_count;
    logic             cnt_overflow, cnt_clr, cnt_en, result_valid, sat, busy;
    logic [RES_W-1:0] result;

    // saturation instance
    logic              start_s = 0, stop_s = 0, pulse_s = 0, ready_s = 0;
    logic [2:0]        cnt_count_s;
    logic              cnt_overflow_s, cnt_clr_s, cnt_en_s, valid_s, sat_s, busy_s;
    logic [RES_WS-1:0] result_s;

    pulse_window_ctrl #(.WIN_CYCLES(WIN), .TMR_W(16), .EXT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pulse_in(pulse_in),
        .cnt_count(cnt_count), .cnt_overflow(cnt_overflow), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .sat(sat), .busy(busy)
    );

    pulse_window_ctrl #(.WIN_CYCLES(WIN_S), .TMR_W(16), .EXT_W(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .stop(stop_s), .pulse_in(pulse_s),
        .cnt_count(cnt_count_s), .cnt_overflow(cnt_overflow_s), .cnt_clr(cnt_clr_s), .cnt_en(cnt_en_s),
        .result(result_s), .result_valid(valid_s), .result_ready(ready_s),
        .sat(sat_s), .busy(busy_s)
    );

    // external 3-bit counters the controller drives
    always_ff @(posedge clk) begin
        if (cnt_clr) cnt_count <= 3'd0;
        else if (cnt_en) cnt_count <= cnt_count + 3'd1;
        if (cnt_clr_s) cnt_count_s <= 3'd0;
        else if (cnt_en_s) cnt_count_s <= cnt_count_s + 3'd1;
    end
    assign cnt_overflow   = (cnt_count == 3'd7) && cnt_en;
    assign cnt_overflow_s = (cnt_count_s == 3'd7) && cnt_en_s;

    int checks = 0;
    int errors = 0;
    bit prev_p = 0;

    typedef struct {
        int mode;       // 0 none, 1 toggle, 2 random, 3 constant high
        int stop_at;    // -2 no stop, -1 stop in CLEAR, else COUNT cycle index
        int rwait;      // cycles result_ready stays low
        bit noisy;      // hold start/stop while busy
        int exp_res;    // expected result, -1 = use model
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pulse(input bit v, output bit e);
        pulse_in = v;
        e = v & ~prev_p;
        prev_p = v;
    endtask

    function automatic bit pick(input int mode, input int c);
        case (mode)
            0: return 1'b0;
            1: return (c % 2) == 0;
            3: return 1'b1;
            default: return $urandom_range(0, 99) < 60;
        endcase
    endfunction

    task automatic run_window(input int mode, input int stop_at, input int rwait,
                              input bit noisy, input int exp_fixed);
        int total;
        bit e;
        logic [RES_W-1:0] exp_res;
        bit exp_sat;
        total = 0;
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1;
        stop  = 0;
        drive_pulse(mode == 2 ? pick(2, 0) : 1'b0, e);
        tick;
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_cnt_clr", 32'(cnt_clr), 32'd1);
        chk("clear_valid", 32'(result_valid), 32'd0);
        start = noisy;
        stop  = (stop_at == -1);
        drive_pulse(mode == 2 ? pick(2, 0) : 1'b0, e);
        if (stop_at != -1) begin
            for (int c = 0; c < WIN; c++) begin
                tick;
                stop = (c == stop_at);
                drive_pulse(pick(mode, c), e);
                total += int'(e);
                #1;
                chk("count_cnt_en", 32'(cnt_en), 32'(e));
                chk("count_cnt_clr", 32'(cnt_clr), 32'd0);
                if (stop) break;
            end
        end
        tick;
        stop = noisy;
        chk("capture_valid", 32'(result_valid), 32'd0);
        chk("capture_busy", 32'(busy), 32'd1);
        drive_pulse(pick(2, 0), e);
        #1;
        chk("capture_cnt_en", 32'(cnt_en), 32'd0);
        tick;
        exp_sat = total >= (1 << RES_W);
        exp_res = exp_sat ? '1 : RES_W'(total);
        if (exp_fixed >= 0) exp_res = RES_W'(exp_fixed);
        chk("hold_valid", 32'(result_valid), 32'd1);
        chk("hold_result", 32'(result), 32'(exp_res));
        chk("hold_sat", 32'(sat), 32'(exp_sat));
        for (int w = 0; w < rwait; w++) begin
            drive_pulse(pick(2, 0), e);
            #1;
            chk("hold_cnt_en", 32'(cnt_en), 32'd0);
            tick;
            chk("stall_valid", 32'(result_valid), 32'd1);
            chk("stall_result", 32'(result), 32'(exp_res));
            chk("stall_busy", 32'(busy), 32'd1);
        end
        result_ready = 1;
        start = 0;
        stop  = 0;
        tick;
        chk("ack_valid", 32'(result_valid), 32'd0);
        chk("ack_busy", 32'(busy), 32'd0);
        result_ready = 0;
        $display("window mode=%0d stop_at=%0d rwait=%0d edges=%0d result=%0h expected=%0h",
                 mode, stop_at, rwait, total, result, exp_res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit e;
        vecs[0] = '{1, -2,  0, 0, 10};   // full window, edge every 2 cycles
        vecs[1] = '{1,  4,  2, 1,  3};   // stop after 3 edges, start held
        vecs[2] = '{0, -2,  1, 0,  0};   // no pulses
        vecs[3] = '{1, -1,  0, 0,  0};   // stop during CLEAR
        vecs[4] = '{1,  0, 10, 0,  1};   // stop first cycle, ready low 10 cycles
        vecs[5] = '{1, 19,  3, 1, 10};   // stop in the last COUNT cycle
        vecs[6] = '{3, -2,  0, 0,  1};   // level high counts once

        #1 rst_n = 0;
        #1;
        chk("rst_cnt_clr", 32'(cnt_clr), 32'd1);
        chk("rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick;
        tick;
        rst_n = 1;
        tick;

        foreach (vecs[i])
            run_window(vecs[i].mode, vecs[i].stop_at, vecs[i].rwait, vecs[i].noisy, vecs[i].exp_res);

        // reset in the middle of COUNT after 5 edges
        start = 1;
        drive_pulse(1'b0, e);
        tick;
        start = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            drive_pulse(pick(1, c), e);
        end
        #2 rst_n = 0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt_clr", 32'(cnt_clr), 32'd1);
        chk("abort_cnt_en", 32'(cnt_en), 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_sat", 32'(sat), 32'd0);
        tick;
        tick;
        chk("abort_valid_hold", 32'(result_valid), 32'd0);
        rst_n = 1;
        tick;
        $display("reset abort applied after 5 edges");
        run_window(1, -2, 0, 0, 10);

        // EXT_W=1: 20 edges exceed 15, so ext saturates and result is all ones
        start_s = 1;
        pulse_s = 0;
        tick;
        start_s = 0;
        chk("sat_clear_busy", 32'(busy_s), 32'd1);
        for (int c = 0; c < WIN_S; c++) begin
            tick;
            pulse_s = (c % 2) == 0;
        end
        tick;
        pulse_s = 0;
        tick;
        chk("sat_valid", 32'(valid_s), 32'd1);
        chk("sat_flag", 32'(sat_s), 32'd1);
        chk("sat_result", 32'(result_s), 32'hF);
        ready_s = 1;
        tick;
        ready_s = 0;
        chk("sat_ack_valid", 32'(valid_s), 32'd0);
        chk("sat_ack_busy", 32'(busy_s), 32'd0);
        chk("sat_flag_kept", 32'(sat_s), 32'd1);
        $display("saturation window edges=20 result=%0h sat=%0b", result_s, sat_s);

        for (int i = 0; i < 25; i++) begin
            int r;
            int sa;
            r = int'($urandom_range(0, 9));
            if (r < 6) sa = -2;
            else if (r == 6) sa = -1;
            else sa = int'($urandom_range(0, WIN - 1));
            run_window(2, sa, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
